// File: rtl/pc_pkg.sv
// Shared types and constants for the program counter / trap unit.
// Latency: n/a (declarations only).
// Backpressure: n/a. Build option PC_COMPRESSED_EN selects 16-bit instruction alignment.
package pc_pkg;

   // Jump/branch code presented by the decoder each cycle
   typedef enum logic [2:0] {
      NONE = 3'd0,
      JAL  = 3'd1,
      JALR = 3'd2,
      BEQ  = 3'd3,
      BNE  = 3'd4,
      BLT  = 3'd5,
      BGE  = 3'd6,
      MRET = 3'd7
   } br_type_t;

   // Trap controller states
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      TRAP = 2'd1,
      HALT = 2'd2
   } state_t;

   // Values reported on the cause output
   localparam logic [1:0] CAUSE_MISALIGN = 2'd0;
   localparam logic [1:0] CAUSE_TRAP_REQ = 2'd1;

   // Sequential increments for full-width and compressed instructions
   localparam int unsigned INC_WORD = 4;
   localparam int unsigned INC_HALF = 2;

`ifdef PC_COMPRESSED_EN
   // Compressed instructions only require halfword alignment
   localparam logic [1:0] ALIGN = 2'b01;
`else
   localparam logic [1:0] ALIGN = 2'b11;
`endif

endpackage

// File: rtl/pc_trap_unit_branch_resolve.sv
// Resolves branch direction, next pc and target misalignment from the current pc.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is committed.
module branch_resolve
   import pc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_pc,
   input  br_type_t        i_branch_type,
   input  logic [XLEN-1:0] i_pc_offset,
   input  logic [XLEN-1:0] i_target_pc,
   input  logic            i_alu_zero,
   input  logic            i_alu_neg,
   input  logic [XLEN-1:0] i_inc,
   output logic [XLEN-1:0] o_next_pc,
   output logic            o_misaligned
);

   logic            w_taken;
   logic [XLEN-1:0] w_target;

   // Branch condition and taken target; JALR clears bit 0 of the absolute target
   always_comb begin
      w_taken  = 1'b0;
      w_target = i_pc + i_pc_offset;
      case (i_branch_type)
         JAL:  w_taken = 1'b1;
         JALR: begin
            w_taken  = 1'b1;
            w_target = {i_target_pc[XLEN-1:1], 1'b0};
         end
         BEQ:  w_taken = i_alu_zero;
         BNE:  w_taken = ~i_alu_zero;
         BLT:  w_taken = i_alu_neg;
         BGE:  w_taken = ~i_alu_neg;
         default: w_taken = 1'b0;   // NONE and MRET fall through sequentially
      endcase
   end

   // Select the taken target or the sequential successor, flag bad alignment
   always_comb begin
      o_next_pc    = w_taken ? w_target : (i_pc + i_inc);
      o_misaligned = w_taken && ((w_target[1:0] & ALIGN) != 2'b00);
   end

endmodule

// File: rtl/pc_trap_unit.sv
// Program counter with trap entry/return and double-fault halt.
// Latency: one edge from inputs to pc/epc/cause/state; return_pc is combinational.
// Backpressure: stay=1 freezes every register; no trap is queued. Option macro: PC_COMPRESSED_EN.
module pc_trap_unit
   import pc_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            stay,
   input  br_type_t        branch_type,
   input  logic [XLEN-1:0] pc_offset,
   input  logic [XLEN-1:0] target_pc,
   input  logic            alu_zero,
   input  logic            alu_neg,
   input  logic            trap_req,
`ifdef PC_COMPRESSED_EN
   input  logic            is_compressed,
`endif
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] return_pc,
   output logic [XLEN-1:0] epc,
   output logic [1:0]      cause,
   output logic            in_trap,
   output logic            halted
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_epc;
   logic [1:0]      r_cause;
   state_t          r_state;
   logic            r_in_trap;
   logic            r_halted;

   logic [XLEN-1:0] w_inc;
   logic [XLEN-1:0] w_next_pc;
   logic            w_misaligned;

   // Increment of the instruction currently at pc
`ifdef PC_COMPRESSED_EN
   assign w_inc = is_compressed ? XLEN'(INC_HALF) : XLEN'(INC_WORD);
`else
   assign w_inc = XLEN'(INC_WORD);
`endif

   branch_resolve #(
      .XLEN (XLEN)
   ) u_branch_resolve (
      .i_pc          (r_pc),
      .i_branch_type (branch_type),
      .i_pc_offset   (pc_offset),
      .i_target_pc   (target_pc),
      .i_alu_zero    (alu_zero),
      .i_alu_neg     (alu_neg),
      .i_inc         (w_inc),
      .o_next_pc     (w_next_pc),
      .o_misaligned  (w_misaligned)
   );

   // Trap FSM: RUN takes the first fault, a second fault in TRAP halts, MRET returns
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc      <= RESET_VEC;
         r_epc     <= '0;
         r_cause   <= CAUSE_MISALIGN;
         r_state   <= RUN;
         r_in_trap <= 1'b0;
         r_halted  <= 1'b0;
      end else if (!stay) begin
         case (r_state)
            RUN: begin
               if (trap_req || w_misaligned) begin
                  r_epc     <= r_pc;
                  r_cause   <= trap_req ? CAUSE_TRAP_REQ : CAUSE_MISALIGN;
                  r_pc      <= TRAP_VEC;
                  r_state   <= TRAP;
                  r_in_trap <= 1'b1;
               end else begin
                  // MRET outside a handler resolves as not-taken, i.e. like NONE
                  r_pc <= w_next_pc;
               end
            end
            TRAP: begin
               if (trap_req || w_misaligned) begin
                  // Double fault: keep pc/epc/cause as evidence and freeze
                  r_state   <= HALT;
                  r_in_trap <= 1'b0;
                  r_halted  <= 1'b1;
               end else if (branch_type == MRET) begin
                  r_pc      <= r_epc + w_inc;
                  r_state   <= RUN;
                  r_in_trap <= 1'b0;
               end else begin
                  r_pc <= w_next_pc;
               end
            end
            HALT: begin
               r_halted <= 1'b1;   // only reset leaves HALT
            end
            default: begin
               r_state   <= RUN;
               r_in_trap <= 1'b0;
               r_halted  <= 1'b0;
            end
         endcase
      end
   end

   assign pc        = r_pc;
   assign return_pc = r_pc + w_inc;
   assign epc       = r_epc;
   assign cause     = r_cause;
   assign in_trap   = r_in_trap;
   assign halted    = r_halted;

endmodule

// File: tb/tb_pc_trap_unit.sv
// Directed bench for pc_trap_unit in the default build (XLEN=32, RESET_VEC=0, TRAP_VEC=0x100).
// Each step drives one cycle of inputs, clocks one edge and compares against hand-computed values.
// Outputs are sampled 1 time unit after the rising edge.
module tb_pc_trap_unit;
   import pc_pkg::*;

   logic        clk;
   logic        rstn;
   logic        stay;
   br_type_t    branch_type;
   logic [31:0] pc_offset;
   logic [31:0] target_pc;
   logic        alu_zero;
   logic        alu_neg;
   logic        trap_req;
`ifdef PC_COMPRESSED_EN
   logic        is_compressed;
`endif
   logic [31:0] pc;
   logic [31:0] return_pc;
   logic [31:0] epc;
   logic [1:0]  cause;
   logic        in_trap;
   logic        halted;

   int n_tests;
   int n_fail;

   pc_trap_unit #(
      .XLEN      (32),
      .RESET_VEC (32'h0000_0000),
      .TRAP_VEC  (32'h0000_0100)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .stay        (stay),
      .branch_type (branch_type),
      .pc_offset   (pc_offset),
      .target_pc   (target_pc),
      .alu_zero    (alu_zero),
      .alu_neg     (alu_neg),
      .trap_req    (trap_req),
`ifdef PC_COMPRESSED_EN
      .is_compressed (is_compressed),
`endif
      .pc          (pc),
      .return_pc   (return_pc),
      .epc         (epc),
      .cause       (cause),
      .in_trap     (in_trap),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, then clock one edge
   task automatic step(input br_type_t bt, input logic [31:0] off, input logic [31:0] tgt,
                       input logic z, input logic n, input logic tr);
      branch_type = bt;
      pc_offset   = off;
      target_pc   = tgt;
      alu_zero    = z;
      alu_neg     = n;
      trap_req    = tr;
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_epc,
                              input logic [1:0] e_cause, input logic e_trap, input logic e_halt);
      check({tag, ".pc"},      pc,              e_pc);
      check({tag, ".epc"},     epc,             e_epc);
      check({tag, ".cause"},   {30'd0, cause},  {30'd0, e_cause});
      check({tag, ".in_trap"}, {31'd0, in_trap}, {31'd0, e_trap});
      check({tag, ".halted"},  {31'd0, halted},  {31'd0, e_halt});
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      rstn        = 1'b0;
      stay        = 1'b0;
      branch_type = NONE;
      pc_offset   = '0;
      target_pc   = '0;
      alu_zero    = 1'b0;
      alu_neg     = 1'b0;
      trap_req    = 1'b0;
`ifdef PC_COMPRESSED_EN
      is_compressed = 1'b0;
`endif
      #1;
      check_state("reset", 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
      check("reset.return_pc", return_pc, 32'h4);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;

      // Sequential fetch
      step(NONE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("seq1.pc", pc, 32'h4);
      check("seq1.return_pc", return_pc, 32'h8);
      step(NONE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("seq2.pc", pc, 32'h8);
      step(NONE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("seq3.pc", pc, 32'hC);
      check("seq3.return_pc", return_pc, 32'h10);

      // Conditional branches
      step(BEQ, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
      check("beq_nt.pc", pc, 32'h10);
      step(BEQ, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
      check("beq_t.pc", pc, 32'h20);

      // Misaligned JALR enters the handler, MRET returns past it
      step(JALR, 32'h0, 32'h46, 1'b0, 1'b0, 1'b0);
      check_state("jalr_mis", 32'h100, 32'h20, CAUSE_MISALIGN, 1'b1, 1'b0);
      step(NONE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check_state("handler_seq", 32'h104, 32'h20, CAUSE_MISALIGN, 1'b1, 1'b0);
      step(MRET, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check_state("mret", 32'h24, 32'h20, CAUSE_MISALIGN, 1'b0, 1'b0);

      // Remaining branch codes, including negative offset wrap
      step(BLT, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1, 1'b0);
      check("blt_t.pc", pc, 32'h20);
      step(BGE, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0);
      check("bge_nt.pc", pc, 32'h24);
      step(JAL, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
      check("jal.pc", pc, 32'h2C);
      step(BNE, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
      check("bne_t.pc", pc, 32'h3C);
      step(BNE, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
      check("bne_nt.pc", pc, 32'h40);
      step(JALR, 32'h0, 32'h81, 1'b0, 1'b0, 1'b0);
      check_state("jalr_bit0", 32'h80, 32'h20, CAUSE_MISALIGN, 1'b0, 1'b0);
      step(MRET, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check_state("mret_in_run", 32'h84, 32'h20, CAUSE_MISALIGN, 1'b0, 1'b0);

      // Misaligned JAL target
      step(JAL, 32'h2, 32'h0, 1'b0, 1'b0, 1'b0);
      check_state("jal_mis", 32'h100, 32'h84, CAUSE_MISALIGN, 1'b1, 1'b0);
      step(MRET, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("mret2.pc", pc, 32'h88);

      // trap_req beats a simultaneous taken branch
      step(BEQ, 32'h40, 32'h0, 1'b1, 1'b0, 1'b1);
      check_state("trap_req", 32'h100, 32'h88, CAUSE_TRAP_REQ, 1'b1, 1'b0);

      // Double fault halts and freezes
      step(NONE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      check_state("halt", 32'h100, 32'h88, CAUSE_TRAP_REQ, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(JALR, 32'h0, 32'h46, 1'b0, 1'b0, 1'b0);
         check_state($sformatf("halt_hold%0d", i), 32'h100, 32'h88, CAUSE_TRAP_REQ, 1'b0, 1'b1);
      end
      step(MRET, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("halt_mret.pc", pc, 32'h100);

      // Asynchronous reset out of HALT
      rstn = 1'b0;
      #2;
      check_state("rst_halt", 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      step(NONE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check_state("rst_resume", 32'h4, 32'h0, 2'd0, 1'b0, 1'b0);

      // stay freezes everything, the held trap is taken exactly once afterwards
      stay = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(JAL, 32'h8, 32'h0, 1'b0, 1'b0, 1'b1);
         check_state($sformatf("stay%0d", i), 32'h4, 32'h0, 2'd0, 1'b0, 1'b0);
      end
      stay = 1'b0;
      step(JAL, 32'h8, 32'h0, 1'b0, 1'b0, 1'b1);
      check_state("stay_release", 32'h100, 32'h4, CAUSE_TRAP_REQ, 1'b1, 1'b0);
      step(NONE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check_state("trap_once", 32'h104, 32'h4, CAUSE_TRAP_REQ, 1'b1, 1'b0);

      // stay also blocks a double fault inside the handler
      stay = 1'b1;
      step(NONE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      check_state("stay_in_trap", 32'h104, 32'h4, CAUSE_TRAP_REQ, 1'b1, 1'b0);
      stay = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_trap_unit.md
PC_TRAP_UNIT -- requirements
Module: pc_trap_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning width of all address ports.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, meaning pc value after reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100, meaning handler entry address.
REQ-004 SHALL have ports (one per line, clock and reset first):
 clk  input  1  single clock, all state on rising edge
 rstn  input  1  asynchronous, active-low reset
 stay  input  1  hold pc and all state this cycle
 branch_type  input  3  jump/branch code (package enum)
 pc_offset  input  XLEN  signed offset added to pc for JAL/branches
 target_pc  input  XLEN  absolute target for JALR
 alu_zero  input  1  ALU result zero
 alu_neg  input  1  ALU result negative
 trap_req  input  1  synchronous trap request (ecall/illegal)
 pc  output  XLEN  current program counter
 return_pc  output  XLEN  pc + INC (link value), combinational
 epc  output  XLEN  saved pc of last trap
 cause  output  2  0 = misaligned target, 1 = trap_req
 in_trap  output  1  handler active
 halted  output  1  double fault, pc frozen

Function
REQ-005 SHALL define INC = 4 and alignment mask ALIGN = 2'b11 (see REQ-021).
REQ-006 SHALL compute branch taken: JAL always; JALR always; BEQ alu_zero; BNE !alu_zero; BLT alu_neg; BGE !alu_neg; NONE never.
REQ-007 SHALL compute next target: JALR -> target_pc with bit 0 cleared; other taken codes -> pc + pc_offset (XLEN-bit wrap, no overflow flag); not taken -> pc + INC (wrap at 2^XLEN).
REQ-008 SHALL flag misaligned when taken and (target & ALIGN) != 0.
REQ-009 SHALL use states RUN, TRAP, HALT; in_trap = (state==TRAP), halted = (state==HALT).
REQ-010 SHALL, per rising edge with stay=0, apply priority: HALT > trap_req > misaligned > MRET > normal update.
REQ-011 SHALL, on trap_req in RUN: epc <= pc, cause <= 1, pc <= TRAP_VEC, state <= TRAP.
REQ-012 SHALL, on misaligned in RUN: epc <= pc, cause <= 0, pc <= TRAP_VEC, state <= TRAP.
REQ-013 SHALL, on trap_req or misaligned in TRAP: epc and cause unchanged, pc unchanged, state <= HALT.
REQ-014 SHALL, on branch_type MRET (3'd7) in TRAP: pc <= epc + INC, state <= RUN; MRET in RUN SHALL behave as NONE.
REQ-015 SHALL hold pc and every register while stay=1, regardless of trap_req or branch_type; no trap is lost or queued.
REQ-016 SHALL, in HALT, keep pc, epc, cause constant until reset.
REQ-017 SHALL have one-edge latency: inputs sampled at edge N determine pc after edge N.

Reset
REQ-018 SHALL, while rstn=0 (asynchronous), force pc = RESET_VEC, epc = 0, cause = 0, state = RUN.
REQ-019 SHALL, on reset asserted mid-trap or in HALT, abandon the trap and resume at RESET_VEC on first edge after release.

Configuration
REQ-020 SHALL support macro PC_COMPRESSED_EN.
REQ-021 SHALL, with PC_COMPRESSED_EN defined, use ALIGN = 2'b01 and INC = 2, add input is_compressed (1 bit) selecting INC = 2 when 1, 4 when 0; without it INC = 4, ALIGN = 2'b11, no is_compressed port.

Structure
REQ-022 SHALL place branch_type enum (NONE, JAL, JALR, BEQ, BNE, BLT, BGE, MRET = 0..7), cause constants and state enum in shared package pc_pkg.
REQ-023 SHALL isolate taken/target/misalign logic in combinational sub-module branch_resolve.

Verification (XLEN=32, RESET_VEC=0, TRAP_VEC=0x100)
REQ-024 Reset release, branch_type NONE 3 edges -> pc 0,4,8,0xC; return_pc = pc+4.
REQ-025 pc=0xC, BEQ, alu_zero=1, pc_offset=0x10 -> pc 0x1C; same with alu_zero=0 -> pc 0x10.
REQ-026 pc=0x20, JALR, target_pc=0x46 -> pc 0x100, epc 0x20, cause 0, in_trap 1; then MRET -> pc 0x24, in_trap 0.
REQ-027 In TRAP, trap_req=1 -> halted 1, pc stays 0x100 for 5 edges; rstn pulse -> pc 0, halted 0.
REQ-028 stay=1 with trap_req=1 and JAL for 3 edges -> pc, epc, state unchanged; stay=0 -> trap taken once.
REQ-029 PC_COMPRESSED_EN: is_compressed=1 -> pc +2 per edge; JALR to 0x46 -> pc 0x46, no trap.
